// File: rtl/count_connected_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : countConnectedDispatchPkg
//  Description : Shared types and constants for the count-connected
//                dispatcher: FSM state encoding, fixed datapath widths and
//                the dispatch/merge pipeline latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
package countConnectedDispatchPkg;

    // Explicit 2-bit encoding so the state register width is fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dispState_t;

    localparam int DISPATCH_LATENCY = 1;
    localparam int MERGE_LATENCY    = 1;

    localparam int GRAPH_WIDTH = 128;
    localparam int COUNT_WIDTH = 6;

endpackage
`default_nettype wire

// File: rtl/count_connected_dispatcher_if.sv
`default_nettype none
// ============================================================================
//  Module      : count_connected_dispatcher_if
//  Description : Upstream item stream and merged result stream of the
//                dispatcher.
//                master : producer/consumer side (drives inValid, graphIn,
//                         extraDataIn; observes inReady and results)
//                slave  : dispatcher side
//  Revision    : 1.0 - initial release
// ============================================================================
interface count_connected_dispatcher_if
    import countConnectedDispatchPkg::*;
#(
    parameter int EXTRA_DATA_WIDTH = 1
);
    logic                        inValid;
    logic                        inReady;
    logic [GRAPH_WIDTH-1:0]      graphIn;
    logic [EXTRA_DATA_WIDTH-1:0] extraDataIn;

    logic                        resultValid;
    logic [COUNT_WIDTH-1:0]      connectCount;
    logic [EXTRA_DATA_WIDTH-1:0] extraDataOut;

    modport master (
        output inValid, graphIn, extraDataIn,
        input  inReady, resultValid, connectCount, extraDataOut
    );

    modport slave (
        input  inValid, graphIn, extraDataIn,
        output inReady, resultValid, connectCount, extraDataOut
    );
endinterface
`default_nettype wire

// File: rtl/count_connected_dispatcher_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : roundRobinSkipArbiter
//  Description : Combinational round-robin arbiter. Starting at i_pointer and
//                wrapping modulo NUM_CORES, grants the first requesting core.
//  Ports       : i_request  - per-core request mask
//                i_pointer  - round-robin start index
//                o_grant    - one-hot grant (zero when nothing requests)
//                o_grantIdx - index of the granted core
//                o_anyGrant - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module roundRobinSkipArbiter #(
    parameter int NUM_CORES = 4,
    parameter int IDX_WIDTH = 2
) (
    input  wire logic [NUM_CORES-1:0] i_request,
    input  wire logic [IDX_WIDTH-1:0] i_pointer,
    output logic      [NUM_CORES-1:0] o_grant,
    output logic      [IDX_WIDTH-1:0] o_grantIdx,
    output logic                      o_anyGrant
);

    int w_cand;

    always_comb begin
        o_grant    = '0;
        o_grantIdx = '0;
        o_anyGrant = 1'b0;
        w_cand     = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_cand = (int'(i_pointer) + k) % NUM_CORES;
            if (!o_anyGrant && i_request[w_cand]) begin
                o_anyGrant       = 1'b1;
                o_grant[w_cand]  = 1'b1;
                o_grantIdx       = w_cand[IDX_WIDTH-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/count_connected_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : count_connected_dispatcher
//  Description : Spreads one stream of bot graphs over NUM_CORES streaming
//                count-connected cores (round-robin, skipping slowed cores)
//                and merges their fixed-latency results back into one
//                in-order stream, checked by a per-item sequence tag.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                start, flush      - FSM control pulses
//                bus (slave)       - item input stream / merged result stream
//                coreBotValid,
//                coreGraph,
//                coreExtraData     - registered dispatch to the cores
//                coreSlowDown      - per-core almost-full
//                coreResultValid,
//                coreConnectCount,
//                coreExtraDataOut,
//                coreEcc           - per-core results
//                eccStatus         - registered OR of coreEcc
//                protocolError     - sticky ordering/collision/counter error
//                drained           - high while in DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module count_connected_dispatcher
    import countConnectedDispatchPkg::*;
#(
    parameter int NUM_CORES        = 4,
    parameter int EXTRA_DATA_WIDTH = 1,
    parameter int SEQ_WIDTH        = 10,
    parameter int INFLIGHT_WIDTH   = 10
) (
    input  wire logic                                            clk,
    input  wire logic                                            rst,
    input  wire logic                                            start,
    input  wire logic                                            flush,
    count_connected_dispatcher_if.slave                          bus,
    output logic      [NUM_CORES-1:0]                            coreBotValid,
    output logic      [GRAPH_WIDTH-1:0]                          coreGraph,
    output logic      [SEQ_WIDTH+EXTRA_DATA_WIDTH-1:0]           coreExtraData,
    input  wire logic [NUM_CORES-1:0]                            coreSlowDown,
    input  wire logic [NUM_CORES-1:0]                            coreResultValid,
    input  wire logic [COUNT_WIDTH*NUM_CORES-1:0]                coreConnectCount,
    input  wire logic [(SEQ_WIDTH+EXTRA_DATA_WIDTH)*NUM_CORES-1:0] coreExtraDataOut,
    input  wire logic [NUM_CORES-1:0]                            coreEcc,
    output logic                                                 eccStatus,
    output logic                                                 protocolError,
    output logic                                                 drained
);

    localparam int                      c_idxWidth    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int                      c_sxWidth     = SEQ_WIDTH + EXTRA_DATA_WIDTH;
    localparam logic [c_idxWidth-1:0]   c_lastIdx     = c_idxWidth'(NUM_CORES - 1);
    localparam logic [INFLIGHT_WIDTH-1:0] c_inflightMax = {INFLIGHT_WIDTH{1'b1}};

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    dispState_t r_state;
    dispState_t w_nextState;
    logic       w_allIdle;
    logic       w_running;
    logic       w_restart;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (start)     w_nextState = ST_RUN;
            ST_RUN:   if (flush)     w_nextState = ST_DRAIN;
            ST_DRAIN: if (w_allIdle) w_nextState = ST_DONE;
            ST_DONE:  if (start)     w_nextState = ST_RUN;
            default:                 w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        w_running = (r_state == ST_RUN);
        // Leaving IDLE/DONE restarts both tag sequences from zero.
        w_restart = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    end

    // ------------------------------------------------------------------
    // Dispatch
    // ------------------------------------------------------------------
    logic [c_idxWidth-1:0] r_ptr;
    logic [SEQ_WIDTH-1:0]  r_issueSeq;
    logic [NUM_CORES-1:0]  w_grant;
    logic [c_idxWidth-1:0] w_grantIdx;
    logic                  w_anyGrant;
    logic                  w_accept;

    roundRobinSkipArbiter #(
        .NUM_CORES (NUM_CORES),
        .IDX_WIDTH (c_idxWidth)
    ) u_arbiter (
        .i_request  (~coreSlowDown),
        .i_pointer  (r_ptr),
        .o_grant    (w_grant),
        .o_grantIdx (w_grantIdx),
        .o_anyGrant (w_anyGrant)
    );

    assign bus.inReady = w_running && w_anyGrant;
    assign w_accept    = bus.inValid && bus.inReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            coreBotValid  <= '0;
            coreGraph     <= '0;
            coreExtraData <= '0;
            r_ptr         <= '0;
            r_issueSeq    <= '0;
        end else begin
            coreBotValid <= w_accept ? w_grant : '0;
            if (w_accept) begin
                coreGraph     <= bus.graphIn;
                coreExtraData <= {r_issueSeq, bus.extraDataIn};
                r_ptr         <= (w_grantIdx == c_lastIdx) ? '0 : w_grantIdx + 1'b1;
                r_issueSeq    <= r_issueSeq + 1'b1;
            end else if (w_restart) begin
                r_issueSeq <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-core in-flight counters
    // ------------------------------------------------------------------
    logic [NUM_CORES-1:0] w_overflow;
    logic [NUM_CORES-1:0] w_underflow;
    logic [NUM_CORES-1:0] w_cntZero;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_inflight
        logic [INFLIGHT_WIDTH-1:0] r_count;
        logic                      w_inc;
        logic                      w_dec;

        assign w_inc = coreBotValid[i];
        assign w_dec = coreResultValid[i];

        // Counter saturates; the attempted over/underflow is flagged instead.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_count <= '0;
            end else if (w_inc && !w_dec) begin
                if (r_count != c_inflightMax) r_count <= r_count + 1'b1;
            end else if (w_dec && !w_inc) begin
                if (r_count != '0) r_count <= r_count - 1'b1;
            end
        end

        assign w_overflow[i]  = w_inc && !w_dec && (r_count == c_inflightMax);
        assign w_underflow[i] = w_dec && !w_inc && (r_count == '0);
        assign w_cntZero[i]   = (r_count == '0);
    end

    // A dispatch strobe still on the wire has not been counted yet.
    assign w_allIdle = (&w_cntZero) && (coreBotValid == '0);

    // ------------------------------------------------------------------
    // Merge
    // ------------------------------------------------------------------
    logic [SEQ_WIDTH-1:0]        r_expectSeq;
    logic [COUNT_WIDTH-1:0]      w_selCount;
    logic [SEQ_WIDTH-1:0]        w_selTag;
    logic [EXTRA_DATA_WIDTH-1:0] w_selExtra;
    logic                        w_anyResult;
    logic                        w_collision;
    logic                        w_seqErr;

    // Descending scan so the lowest-index valid core wins.
    always_comb begin
        w_selCount = '0;
        w_selTag   = '0;
        w_selExtra = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (coreResultValid[k]) begin
                w_selCount             = coreConnectCount[k*COUNT_WIDTH +: COUNT_WIDTH];
                {w_selTag, w_selExtra} = coreExtraDataOut[k*c_sxWidth +: c_sxWidth];
            end
        end
    end

    assign w_anyResult = |coreResultValid;
    assign w_collision = (coreResultValid & (coreResultValid - 1'b1)) != '0;
    assign w_seqErr    = w_anyResult && (w_selTag != r_expectSeq);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.resultValid  <= 1'b0;
            bus.connectCount <= '0;
            bus.extraDataOut <= '0;
            r_expectSeq      <= '0;
            protocolError    <= 1'b0;
            eccStatus        <= 1'b0;
            drained          <= 1'b0;
        end else begin
            bus.resultValid <= w_anyResult;
            if (w_anyResult) begin
                bus.connectCount <= w_selCount;
                bus.extraDataOut <= w_selExtra;
                r_expectSeq      <= r_expectSeq + 1'b1;
            end else if (w_restart) begin
                r_expectSeq <= '0;
            end
            protocolError <= protocolError | w_collision | w_seqErr
                             | (|w_overflow) | (|w_underflow);
            eccStatus     <= |coreEcc;
            drained       <= (w_nextState == ST_DONE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_count_connected_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_count_connected_dispatcher
//  Description : Directed self-checking bench for count_connected_dispatcher
//                with a fixed-latency core bank model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_connected_dispatcher;
    import countConnectedDispatchPkg::*;

    localparam int NC  = 4;
    localparam int EW  = 1;
    localparam int SW  = 10;
    localparam int XW  = SW + EW;
    localparam int LAT = 520;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    count_connected_dispatcher_if #(.EXTRA_DATA_WIDTH(EW)) bus ();

    logic [NC-1:0]    coreBotValid, coreSlowDown, coreResultValid, coreEcc;
    logic [127:0]     coreGraph;
    logic [XW-1:0]    coreExtraData;
    logic [6*NC-1:0]  coreConnectCount;
    logic [XW*NC-1:0] coreExtraDataOut;
    logic             eccStatus, protocolError, drained;

    count_connected_dispatcher #(
        .NUM_CORES(NC), .EXTRA_DATA_WIDTH(EW), .SEQ_WIDTH(SW), .INFLIGHT_WIDTH(10)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .bus(bus),
        .coreBotValid(coreBotValid), .coreGraph(coreGraph), .coreExtraData(coreExtraData),
        .coreSlowDown(coreSlowDown), .coreResultValid(coreResultValid),
        .coreConnectCount(coreConnectCount), .coreExtraDataOut(coreExtraDataOut),
        .coreEcc(coreEcc), .eccStatus(eccStatus), .protocolError(protocolError),
        .drained(drained)
    );

    // Result source: core model or directly injected values.
    logic             useModel;
    logic [NC-1:0]    mRV, dRV;
    logic [5:0]       mC;
    logic [XW-1:0]    mX;
    logic [6*NC-1:0]  dC;
    logic [XW*NC-1:0] dX;

    assign coreResultValid  = useModel ? mRV : dRV;
    assign coreConnectCount = useModel ? {NC{mC}} : dC;
    assign coreExtraDataOut = useModel ? {NC{mX}} : dX;

    // Core bank model: every dispatch returns LAT cycles later with
    // count = graph[5:0] and the sideband echoed back.
    logic [NC-1:0] ringV [1024];
    logic [5:0]    ringC [1024];
    logic [XW-1:0] ringX [1024];
    int unsigned   mCyc;

    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 1024; k++) begin
                ringV[k] = '0;
                ringC[k] = '0;
                ringX[k] = '0;
            end
            mCyc = 0;
            mRV  = '0;
            mC   = '0;
            mX   = '0;
        end else begin
            ringV[mCyc % 1024] = coreBotValid;
            ringC[mCyc % 1024] = coreGraph[5:0];
            ringX[mCyc % 1024] = coreExtraData;
            mRV  = ringV[(mCyc + 1024 - LAT) % 1024];
            mC   = ringC[(mCyc + 1024 - LAT) % 1024];
            mX   = ringX[(mCyc + 1024 - LAT) % 1024];
            mCyc = mCyc + 1;
        end
    end

    // Result monitor: {extra, count} of every merged result.
    logic [6:0] rxQ [$];
    int         rxCount = 0;
    always @(negedge clk) begin
        if (!rst && bus.resultValid) begin
            rxQ.push_back({bus.extraDataOut, bus.connectCount});
            rxCount = rxCount + 1;
        end
    end

    int nCmp = 0;
    int nErr = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitRx(input string tag, input int n, input int budget);
        int c;
        c = 0;
        while (rxCount < n && c < budget) begin
            tick();
            c++;
        end
        check(tag, 128'(rxCount), 128'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int c;
        int base;

        useModel = 1'b1;
        dRV = '0; dC = '0; dX = '0;
        coreSlowDown = '0;
        coreEcc = '0;
        bus.inValid = 1'b0;
        bus.graphIn = '0;
        bus.extraDataIn = '0;

        // Reset state
        repeat (3) tick();
        check("rst_inReady",       128'(bus.inReady), 0);
        check("rst_coreBotValid",  128'(coreBotValid), 0);
        check("rst_coreExtraData", 128'(coreExtraData), 0);
        check("rst_coreGraph",     coreGraph, 0);
        check("rst_resultValid",   128'(bus.resultValid), 0);
        check("rst_protocolError", 128'(protocolError), 0);
        check("rst_drained",       128'(drained), 0);
        rst = 1'b0;
        tick();
        check("idle_inReady", 128'(bus.inReady), 0);

        // ECC flag is a one-cycle registered OR
        coreEcc = 4'b0100;
        tick();
        check("ecc_set", 128'(eccStatus), 1);
        coreEcc = '0;
        tick();
        check("ecc_clr", 128'(eccStatus), 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_inReady", 128'(bus.inReady), 1);

        // Test 1: 8 back-to-back items, round-robin over all cores, tags 0..7
        for (int i = 0; i < 8; i++) begin
            bus.inValid = 1'b1;
            bus.graphIn = 128'(i + 1);
            bus.extraDataIn = i[0];
            tick();
            check("t1_botValid", 128'(coreBotValid), 128'(4'b0001 << (i % 4)));
            check("t1_coreExtraData", 128'(coreExtraData), 128'({SW'(i), i[0]}));
        end
        bus.inValid = 1'b0;
        waitRx("t1_count", 8, 700);
        for (int i = 0; i < 8; i++)
            check("t1_result", 128'(rxQ[i]), 128'({i[0], 6'(i + 1)}));

        // Test 2: core 1 slowed -> grants 0,2,3,0
        coreSlowDown = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            bus.inValid = 1'b1;
            bus.graphIn = 128'(16 + i);
            bus.extraDataIn = i[0];
            tick();
            case (i)
                0:       check("t2_botValid", 128'(coreBotValid), 128'(4'b0001));
                1:       check("t2_botValid", 128'(coreBotValid), 128'(4'b0100));
                2:       check("t2_botValid", 128'(coreBotValid), 128'(4'b1000));
                default: check("t2_botValid", 128'(coreBotValid), 128'(4'b0001));
            endcase
        end
        bus.inValid = 1'b0;
        coreSlowDown = 4'b1111;
        #1;
        check("t2_allSlow_inReady", 128'(bus.inReady), 0);
        coreSlowDown = '0;
        waitRx("t2_count", 12, 700);
        for (int i = 0; i < 4; i++)
            check("t2_result", 128'(rxQ[8 + i]), 128'({i[0], 6'(16 + i)}));

        // Test 3: 600 items with random gaps, results in order
        for (int i = 0; i < 600; i++) begin
            bus.inValid = 1'b1;
            bus.graphIn = 128'(i % 64);
            bus.extraDataIn = i[0];
            tick();
            bus.inValid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        waitRx("t3_count", 612, 1500);
        for (int i = 0; i < 600; i++)
            check("t3_result", 128'(rxQ[12 + i]), 128'({i[0], 6'(i % 64)}));
        check("t3_protocolError", 128'(protocolError), 0);

        // Test 6: 10 items, flush, drain, restart from tag 0
        for (int i = 0; i < 10; i++) begin
            bus.inValid = 1'b1;
            bus.graphIn = 128'(32 + i);
            bus.extraDataIn = 1'b0;
            tick();
        end
        bus.inValid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t6_flush_inReady", 128'(bus.inReady), 0);
        check("t6_flush_drained", 128'(drained), 0);
        seen = 0;
        c = 0;
        while (seen < 10 && c < 800) begin
            tick();
            c++;
            if (bus.resultValid) seen++;
        end
        check("t6_results", 128'(seen), 10);
        check("t6_drained_low", 128'(drained), 0);
        tick();
        check("t6_drained_high", 128'(drained), 1);
        check("t6_done_inReady", 128'(bus.inReady), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_restart_inReady", 128'(bus.inReady), 1);
        bus.inValid = 1'b1;
        bus.graphIn = 128'(42);
        bus.extraDataIn = 1'b1;
        tick();
        bus.inValid = 1'b0;
        check("t6_restart_botValid", 128'(coreBotValid), 128'(4'b1000));
        check("t6_restart_tag", 128'(coreExtraData), 128'({10'd0, 1'b1}));
        waitRx("t6_restart_count", 623, 700);
        check("t6_restart_result", 128'(rxQ[622]), 128'({1'b1, 6'd42}));
        check("t6_protocolError", 128'(protocolError), 0);

        // Test 4: collision 0101 -> core 0 forwarded, sticky error
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.inValid = 1'b1;
            bus.graphIn = 128'(i);
            bus.extraDataIn = 1'b0;
            tick();
        end
        bus.inValid = 1'b0;
        tick();
        useModel = 1'b0;
        dRV = 4'b0101;
        dC = '0;
        dC[5:0]   = 6'd21;
        dC[17:12] = 6'd42;
        dX = '0;
        dX[10:0]  = {10'd0, 1'b1};
        dX[32:22] = {10'd2, 1'b0};
        check("t4_pre_protocolError", 128'(protocolError), 0);
        tick();
        dRV = '0;
        check("t4_resultValid",   128'(bus.resultValid), 1);
        check("t4_connectCount",  128'(bus.connectCount), 21);
        check("t4_extraDataOut",  128'(bus.extraDataOut), 1);
        check("t4_protocolError", 128'(protocolError), 1);
        repeat (3) tick();
        check("t4_sticky", 128'(protocolError), 1);

        // Test 5: tag 5 arrives while 4 is expected
        rst = 1'b1;
        useModel = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        base = rxCount;
        for (int i = 0; i < 4; i++) begin
            bus.inValid = 1'b1;
            bus.graphIn = 128'(i);
            bus.extraDataIn = 1'b0;
            tick();
        end
        bus.inValid = 1'b0;
        repeat (10) tick();
        bus.inValid = 1'b1;
        tick();
        bus.inValid = 1'b0;
        waitRx("t5_first4", base + 4, 700);
        useModel = 1'b0;
        check("t5_pre_protocolError", 128'(protocolError), 0);
        dRV = 4'b0001;
        dC = '0;
        dX = '0;
        dX[10:0] = {10'd5, 1'b0};
        tick();
        dRV = '0;
        check("t5_resultValid", 128'(bus.resultValid), 1);
        check("t5_protocolError", 128'(protocolError), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_connected_dispatcher.md
# count_connected_dispatcher

Spreads one stream of leaf-eliminated bot graphs over `NUM_CORES` streaming count-connected cores and merges their results back into one in-order output stream. It sits between the bot/permutation producer and the core bank, on the core-bank clock. Routing is round-robin and skips cores that assert slow-down. Every input gets a sequence tag, and the merger uses that tag to check ordering and detect result collisions, because the cores return results on a fixed, unstallable schedule. A small FSM sequences start, run, drain and done.

## Interface
- `NUM_CORES`, 4: number of cores driven; 2..8.
- `EXTRA_DATA_WIDTH`, 1: user sideband width carried through the cores.
- `SEQ_WIDTH`, 10: sequence tag width. It must cover core latency plus in-flight items.
- `INFLIGHT_WIDTH`, 10: width of each per-core in-flight counter.

Ports (clock and reset first):
- `clk` in 1: single clock. Synchronous, active-high reset.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse; IDLE->RUN.
- `flush` in 1: pulse; RUN->DRAIN.
- `inValid` in 1: input item valid.
- `inReady` out 1: accept when `inValid && inReady`.
- `graphIn` in 128: graph.
- `extraDataIn` in `EXTRA_DATA_WIDTH`: user sideband.
- `coreBotValid` out `NUM_CORES`: one-hot or zero; dispatch strobe to each core.
- `coreGraph` out 128: broadcast graph.
- `coreExtraData` out `SEQ_WIDTH+EXTRA_DATA_WIDTH`: broadcast `{seq, extra}`.
- `coreSlowDown` in `NUM_CORES`: per-core almost-full.
- `coreResultValid` in `NUM_CORES`: per-core result strobe.
- `coreConnectCount` in `6*NUM_CORES`: packed per-core counts; core i is at [6i+5:6i].
- `coreExtraDataOut` in `(SEQ_WIDTH+EXTRA_DATA_WIDTH)*NUM_CORES`: packed per-core sideband.
- `coreEcc` in `NUM_CORES`: per-core ECC flag.
- `resultValid` out 1: merged result valid.
- `connectCount` out 6: merged count.
- `extraDataOut` out `EXTRA_DATA_WIDTH`: user sideband with the tag stripped.
- `eccStatus` out 1: OR of `coreEcc`, registered.
- `protocolError` out 1: sticky; set on collision, sequence mismatch, or counter overflow/underflow.
- `drained` out 1: level; high in DONE.

## Operation
- States are IDLE, RUN, DRAIN and DONE. Reset puts the FSM in IDLE.
  - IDLE goes to RUN on `start`.
  - RUN goes to DRAIN on `flush`.
  - DRAIN goes to DONE when every in-flight counter is 0.
  - DONE goes to RUN on `start`. This clears both sequence counters, not `protocolError`.
  - `start` outside IDLE/DONE is ignored. `flush` outside RUN is ignored.
- `inReady` = (state==RUN) && (there is a core i with !`coreSlowDown[i]`).
- Dispatch: on acceptance, pick the first non-slowed core at or after the round-robin pointer, wrapping modulo `NUM_CORES`. The pointer then moves to chosen+1, wrapping. The graph and `{issueSeq, extraDataIn}` are registered onto `coreGraph`/`coreExtraData`, and `coreBotValid[chosen]` is pulsed. `issueSeq` increments and wraps at 2^`SEQ_WIDTH`.
- In-flight counter i: +1 on `coreBotValid[i]`, -1 on `coreResultValid[i]`, net 0 when both happen in the same cycle. Overflow or an underflow attempt sets `protocolError`, and the counter saturates.
- Merge: at most one `coreResultValid` bit is high per cycle, which follows from the cores' fixed latency. The selected core's count and sideband are registered to the outputs.
  - Two or more bits high sets `protocolError`. The lowest index is forwarded.
  - The tag must equal `expectSeq`; a mismatch sets `protocolError`. `expectSeq` increments on every forwarded result.
- `protocolError` clears only on `rst`.

## Timing
- Every output except `inReady` is registered. `inReady` is combinational from state and `coreSlowDown`.
- Dispatch latency is 1: an item accepted in cycle t gives `coreBotValid` in t+1.
- Merge latency is 1: `coreResultValid` in t gives `resultValid` in t+1.
- `eccStatus` is `|coreEcc` delayed 1 cycle.
- `drained` rises the cycle after the last in-flight counter reaches 0 while in DRAIN.
- Reset values: `inReady`, `coreBotValid`, `resultValid`, `connectCount`, `extraDataOut`, `coreGraph`, `coreExtraData`, `eccStatus`, `protocolError` and `drained` are all 0. The round-robin pointer, both sequence counters and all in-flight counters are also 0.
- A `flush` in the same cycle as an acceptance: the item is dispatched, and the FSM enters DRAIN the next cycle.
- `rst` mid-run drops every in-flight count. The cores must be reset by the same `rst`.

## Structure
- Package `countConnectedDispatchPkg` holds the FSM state enum and a `DISPATCH_LATENCY=1`/`MERGE_LATENCY=1` constant pair.
- Sub-module `roundRobinSkipArbiter` takes the request mask (the complement of `coreSlowDown`) and the pointer, and returns a one-hot grant, the grant index and any-grant. It is combinational and instantiated once.

## Test plan
1. `NUM_CORES=4`, no slow-down, 8 back-to-back inputs -> `coreBotValid` 0001,0010,0100,1000,0001...; tags 0..7.
2. `coreSlowDown`=0010 held, 4 inputs -> grants go to cores 0,2,3,0 and core 1 gets nothing. With `coreSlowDown`=1111, `inReady`=0.
3. Core model with fixed 520-cycle latency, 600 random-gap inputs -> 600 in-order results, tags 0..599 (wrapping past 2^`SEQ_WIDTH` when it is smaller), `protocolError`=0.
4. Inject `coreResultValid`=0101 in one cycle -> `protocolError`=1 next cycle and stays set; core 0's data is forwarded.
5. Inject a result with tag 5 when 4 is expected -> `protocolError`=1.
6. `flush` after 10 inputs -> `inReady`=0 at once. `drained` rises one cycle after the 10th result. `start` then resumes with tag 0.
